// File: rtl/regfile_scoreboard_if.sv
// Purpose: decode/writeback/control bundle between the decode stage and the
//          register-file issue scoreboard.
// Signals:
//   issue_valid, rs_used/rs_sel, rt_used/rt_sel, wr_used/wr_sel : issue request
//   wb_valid, wb_sel                                            : writeback retire
//   halt_req, resume                                            : drain control pulses
//   stall, issue_fire                                           : same-cycle issue verdict
//   busy, drained, err                                          : status
// Modports: master = decode side (drives requests), slave = scoreboard.
interface regfile_scoreboard_if #(
  parameter int unsigned NREG = 8
);
  localparam int unsigned SEL_W = $clog2(NREG);

  logic             issue_valid;
  logic             rs_used;
  logic [SEL_W-1:0] rs_sel;
  logic             rt_used;
  logic [SEL_W-1:0] rt_sel;
  logic             wr_used;
  logic [SEL_W-1:0] wr_sel;
  logic             wb_valid;
  logic [SEL_W-1:0] wb_sel;
  logic             halt_req;
  logic             resume;
  logic             stall;
  logic             issue_fire;
  logic             busy;
  logic             drained;
  logic             err;

  modport master (
    output issue_valid, rs_used, rs_sel, rt_used, rt_sel, wr_used, wr_sel,
           wb_valid, wb_sel, halt_req, resume,
    input  stall, issue_fire, busy, drained, err
  );

  modport slave (
    input  issue_valid, rs_used, rs_sel, rt_used, rt_sel, wr_used, wr_sel,
           wb_valid, wb_sel, halt_req, resume,
    output stall, issue_fire, busy, drained, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Purpose: decode-stage issue scoreboard. Keeps a pending-write counter per
//          architectural register (up at issue, down at writeback), stalls
//          issue on pending sources or a saturated destination counter, and
//          runs a RUN/DRAIN/HALTED FSM that quiesces issue on request.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   sb    : regfile_scoreboard_if.slave (issue, writeback, control, status)
// Build option: define SB_WB_BYPASS_EN when the register file forwards
//   same-cycle writeback data; a source whose last pending write retires this
//   cycle is then not treated as pending.
module regfile_scoreboard #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  sb
);

  localparam int unsigned SEL_W   = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;

  logic [NREG-1:0]  wb_hit;
  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  nonzero_q;
  logic [NREG-1:0]  nonzero_d;
  logic             wr_full;
  logic             stall_c;
  logic             fire_c;

  // Per-register writeback match and source-pending view
  always_comb begin
    wb_hit    = '0;
    pend      = '0;
    nonzero_q = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      wb_hit[i]    = sb.wb_valid && (sb.wb_sel == SEL_W'(i));
      nonzero_q[i] = (cnt_q[i] != '0);
      pend[i]      = nonzero_q[i];
`ifdef SB_WB_BYPASS_EN
      // last outstanding write retiring now is forwarded by the register file
      if ((cnt_q[i] == CNT_W'(1)) && wb_hit[i]) begin
        pend[i] = 1'b0;
      end
`endif
    end
  end

  // Issue verdict; a saturated destination may still issue if it retires one this cycle
  always_comb begin
    wr_full = sb.wr_used && (cnt_q[sb.wr_sel] == CNT_MAX) && !wb_hit[sb.wr_sel];
    stall_c = (state_q != ST_RUN)
            || (sb.rs_used && pend[sb.rs_sel])
            || (sb.rt_used && pend[sb.rt_sel])
            || wr_full;
    fire_c  = sb.issue_valid && !stall_c;
  end

  // Counter next state and underflow detection
  always_comb begin
    nonzero_d = '0;
    err_d     = sb.wb_valid && (cnt_q[sb.wb_sel] == '0);
    for (int i = 0; i < int'(NREG); i++) begin
      logic inc;
      logic dec;
      inc      = fire_c && sb.wr_used && (sb.wr_sel == SEL_W'(i));
      dec      = wb_hit[i] && nonzero_q[i];
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      nonzero_d[i] = (cnt_d[i] != '0);
    end
  end

  // Halt/drain FSM; DRAIN is skipped when nothing is left in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (sb.halt_req) begin
          state_d = (nonzero_d == '0) ? ST_HALTED : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (nonzero_d == '0) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (sb.resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sb.stall      = stall_c;
  assign sb.issue_fire = fire_c;
  assign sb.busy       = |nonzero_q;
  assign sb.drained    = (state_q == ST_HALTED);
  assign sb.err        = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_scoreboard_if #(.NREG(8)) sbif ();

  regfile_scoreboard #(.NREG(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending count per register and a mode (0 run, 1 drain, 2 halted)
  int cnt_m [8];
  int st_m;
  int err_m;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_pend(input int r);
    if (cnt_m[r] == 0) return 1'b0;
`ifdef SB_WB_BYPASS_EN
    if (cnt_m[r] == 1 && sbif.wb_valid && int'(sbif.wb_sel) == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = (st_m != 0);
    if (sbif.rs_used && m_pend(int'(sbif.rs_sel))) s = 1'b1;
    if (sbif.rt_used && m_pend(int'(sbif.rt_sel))) s = 1'b1;
    if (sbif.wr_used && cnt_m[sbif.wr_sel] == 3 &&
        !(sbif.wb_valid && sbif.wb_sel == sbif.wr_sel)) s = 1'b1;
    return s;
  endfunction

  function automatic bit m_fire();
    return sbif.issue_valid && !m_stall();
  endfunction

  // pending writes after this cycle: one more if issued here, one fewer if retired here
  function automatic int m_next(input int r);
    int n;
    n = cnt_m[r];
    if (m_fire() && sbif.wr_used && int'(sbif.wr_sel) == r) n = n + 1;
    if (sbif.wb_valid && int'(sbif.wb_sel) == r && cnt_m[r] > 0) n = n - 1;
    return n;
  endfunction

  function automatic bit m_next_empty();
    for (int r = 0; r < 8; r++) if (m_next(r) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_busy();
    for (int r = 0; r < 8; r++) if (cnt_m[r] != 0) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) cnt_m[r] <= 0;
      st_m  <= 0;
      err_m <= 0;
    end else begin
      for (int r = 0; r < 8; r++) cnt_m[r] <= m_next(r);
      err_m <= (sbif.wb_valid && cnt_m[sbif.wb_sel] == 0) ? 1 : 0;
      if (st_m == 0 && sbif.halt_req)  st_m <= m_next_empty() ? 2 : 1;
      else if (st_m == 1 && m_next_empty()) st_m <= 2;
      else if (st_m == 2 && sbif.resume)    st_m <= 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall",      int'(sbif.stall),      int'(m_stall()));
      chk("issue_fire", int'(sbif.issue_fire), int'(m_fire()));
      chk("busy",       int'(sbif.busy),       m_busy());
      chk("drained",    int'(sbif.drained),    (st_m == 2) ? 1 : 0);
      chk("err",        int'(sbif.err),        err_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.issue_valid = 1'b0;
    sbif.rs_used = 1'b0; sbif.rs_sel = '0;
    sbif.rt_used = 1'b0; sbif.rt_sel = '0;
    sbif.wr_used = 1'b0; sbif.wr_sel = '0;
    sbif.wb_valid = 1'b0; sbif.wb_sel = '0;
    sbif.halt_req = 1'b0; sbif.resume = 1'b0;
  endtask

  task automatic issue_wr(input int r);
    sbif.issue_valid = 1'b1;
    sbif.wr_used = 1'b1;
    sbif.wr_sel = 3'(r);
  endtask

  initial begin
    int pick;
    int cand [$];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    sbif.issue_valid = 1'b1;
    #12;
    // reset state
    chk("rst_stall",   int'(sbif.stall),      0);
    chk("rst_fire",    int'(sbif.issue_fire), 1);
    chk("rst_busy",    int'(sbif.busy),       0);
    chk("rst_drained", int'(sbif.drained),    0);
    chk("rst_err",     int'(sbif.err),        0);
    rst_n = 1'b1;
    tick();

    // RAW on r3 resolved by writeback
    idle(); issue_wr(3);
    tick();
    idle(); sbif.issue_valid = 1'b1; sbif.rs_used = 1'b1; sbif.rs_sel = 3'd3;
    @(negedge clk);
    chk("t1_raw_stall", int'(sbif.stall), 1);
    tick();
    sbif.wb_valid = 1'b1; sbif.wb_sel = 3'd3;
    @(negedge clk);
`ifdef SB_WB_BYPASS_EN
    chk("t1_wb_stall", int'(sbif.stall), 0);
`else
    chk("t1_wb_stall", int'(sbif.stall), 1);
`endif
    tick();
    sbif.wb_valid = 1'b0;
    @(negedge clk);
    chk("t1_after_stall", int'(sbif.stall), 0);
    chk("t1_model_cnt3", cnt_m[3], 0);
    tick();

    // saturate r5
    idle(); issue_wr(5);
    tick(); tick(); tick();
    @(negedge clk);
    chk("t2_model_cnt5", cnt_m[5], 3);
    chk("t2_full_stall", int'(sbif.stall), 1);
    tick();
    sbif.wb_valid = 1'b1; sbif.wb_sel = 3'd5;
    @(negedge clk);
    chk("t2_wb_fire", int'(sbif.issue_fire), 1);
    tick();
    sbif.issue_valid = 1'b0;
    @(negedge clk);
    chk("t2_model_cnt5_kept", cnt_m[5], 3);
    tick(); tick(); tick();
    sbif.wb_valid = 1'b0;
    @(negedge clk);
    chk("t2_busy_clear", int'(sbif.busy), 0);
    tick();

    // underflow
    idle(); sbif.wb_valid = 1'b1; sbif.wb_sel = 3'd2;
    tick();
    sbif.wb_valid = 1'b0;
    @(negedge clk);
    chk("t3_err", int'(sbif.err), 1);
    chk("t3_busy", int'(sbif.busy), 0);
    tick();
    @(negedge clk);
    chk("t3_err_pulse", int'(sbif.err), 0);
    tick();

    // drain two writes on r1
    idle(); issue_wr(1);
    tick(); tick();
    idle(); sbif.halt_req = 1'b1;
    tick();
    sbif.halt_req = 1'b0;
    @(negedge clk);
    chk("t4_drain_stall", int'(sbif.stall), 1);
    chk("t4_drain_drained", int'(sbif.drained), 0);
    tick();
    sbif.wb_valid = 1'b1; sbif.wb_sel = 3'd1;
    tick(); tick();
    sbif.wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_halted", int'(sbif.drained), 1);
    tick();
    sbif.resume = 1'b1;
    tick();
    sbif.resume = 1'b0;
    @(negedge clk);
    chk("t4_resume_stall", int'(sbif.stall), 0);
    chk("t4_resume_drained", int'(sbif.drained), 0);
    tick();

    // halt with nothing in flight, resume in the same cycle is ignored
    idle(); sbif.halt_req = 1'b1; sbif.resume = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("t5_halted", int'(sbif.drained), 1);
    tick();
    sbif.resume = 1'b1;
    tick();
    sbif.resume = 1'b0;
    @(negedge clk);
    chk("t5_run", int'(sbif.drained), 0);
    tick();

    // asynchronous reset in the middle of a drain
    idle(); issue_wr(4);
    tick(); tick();
    idle(); sbif.halt_req = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("t6_pre_busy", int'(sbif.busy), 1);
    chk("t6_pre_stall", int'(sbif.stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", int'(sbif.busy), 0);
    chk("t6_drained", int'(sbif.drained), 0);
    chk("t6_stall", int'(sbif.stall), 0);
    chk("t6_model_cnt4", cnt_m[4], 0);
    #1 rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      sbif.issue_valid = 1'($urandom_range(0, 1));
      sbif.rs_used = 1'($urandom_range(0, 1)); sbif.rs_sel = 3'($urandom_range(0, 7));
      sbif.rt_used = 1'($urandom_range(0, 1)); sbif.rt_sel = 3'($urandom_range(0, 7));
      sbif.wr_used = 1'($urandom_range(0, 1)); sbif.wr_sel = 3'($urandom_range(0, 7));
      cand.delete();
      for (int r = 0; r < 8; r++) if (cnt_m[r] != 0) cand.push_back(r);
      sbif.wb_valid = ($urandom_range(0, 99) < 45);
      if (cand.size() != 0 && $urandom_range(0, 9) != 0) begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
        sbif.wb_sel = 3'(pick);
      end else begin
        sbif.wb_sel = 3'($urandom_range(0, 7));
      end
      sbif.halt_req = ($urandom_range(0, 39) == 0);
      sbif.resume   = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
